// File: rtl/nl_vc_blocked_tracker_pkg.sv
// Shared router types and helpers: port numbering, XY turn legality and the
// credit-counter width helper.
package nl_vc_blocked_tracker_pkg;

  localparam int NL_NP = 5;

  localparam int NL_PORT_LOCAL = 0;
  localparam int NL_PORT_EAST  = 1;
  localparam int NL_PORT_WEST  = 2;
  localparam int NL_PORT_NORTH = 3;
  localparam int NL_PORT_SOUTH = 4;

  typedef logic [NL_NP-1:0] output_port_t;

  // XY routing: no U-turns (except local), and a flit travelling in Y never turns back into X.
  function automatic bit NL_route_valid_turn(input int in_port, input int out_port);
    bit in_y;
    bit out_x;
    in_y  = (in_port == NL_PORT_NORTH) || (in_port == NL_PORT_SOUTH);
    out_x = (out_port == NL_PORT_EAST) || (out_port == NL_PORT_WEST);
    if ((in_port == out_port) && (in_port != NL_PORT_LOCAL)) return 1'b0;
    if (in_y && out_x) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int nl_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nl_vc_credit_counter.sv
// Per-VC downstream state: saturating credit counter, busy (allocated) flag and
// registered blocked bit. Error conditions leave as single-cycle pulses.
module nl_vc_credit_counter #(
  parameter int BUF_DEPTH = 4,
  parameter int THRESH    = 0,
  parameter int ATOMIC    = 1,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic             sent,
  input  logic             tail,
  input  logic             credit,
  output logic [CNT_W-1:0] cnt,
  output logic             blocked,
  output logic             err_credit,
  output logic             err_realloc
);

  localparam logic [CNT_W-1:0] FULL  = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(THRESH);

  logic [CNT_W-1:0] cnt_nxt;
  logic             busy;
  logic             busy_nxt;
  logic             release_vc;

  always_comb begin
    cnt_nxt     = cnt;
    err_credit  = 1'b0;
    release_vc  = sent & tail;
    // A credit and a send in the same cycle cancel, so only the lone cases move the count.
    if (credit && !sent) begin
      if (cnt == FULL) err_credit = 1'b1;
      else             cnt_nxt    = cnt + 1'b1;
    end else if (sent && !credit) begin
      if (cnt == '0) err_credit = 1'b1;
      else           cnt_nxt    = cnt - 1'b1;
    end
    busy_nxt    = alloc | (busy & ~release_vc);
    err_realloc = alloc & busy & ~release_vc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= FULL;
      busy    <= 1'b0;
      blocked <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      blocked <= (cnt_nxt <= LIMIT) | ((ATOMIC != 0) & busy_nxt);
    end
  end

endmodule

// File: rtl/nl_vc_blocked_tracker.sv
// Stateful VC-blocked tracker for one input port: per-(port,VC) credit/busy state,
// registered blocked map, sticky error flags and a zero-cycle one-hot query.
module nl_vc_blocked_tracker
  import nl_vc_blocked_tracker_pkg::*;
#(
  parameter int input_port = 0,
  parameter int NP         = 5,
  parameter int NV         = 4,
  parameter int BUF_DEPTH  = 4,
  parameter int THRESH     = 0,
  parameter int ATOMIC     = 1,
  parameter int CNT_W      = nl_cnt_w(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NP-1:0]         output_port_sw,
  input  logic [NV-1:0]         vc_blocked_chk,
  input  logic [NP*NV-1:0]      vc_alloc,
  input  logic [NP*NV-1:0]      flit_sent,
  input  logic [NP*NV-1:0]      flit_tail,
  input  logic [NP*NV-1:0]      credit_in,
  output logic                  vc_full_blocked,
  output logic [NP*NV-1:0]      vc_blocked_map,
  output logic [NP*NV*CNT_W-1:0] credit_cnt,
  output logic                  err_credit,
  output logic                  err_realloc
);

  localparam int NVC = NP * NV;

  logic [NVC-1:0] err_credit_evt;
  logic [NVC-1:0] err_realloc_evt;

  for (genvar p = 0; p < NP; p++) begin : g_port
    if (NL_route_valid_turn(input_port, p)) begin : g_legal
      for (genvar v = 0; v < NV; v++) begin : g_vc
        localparam int I = p * NV + v;
        nl_vc_credit_counter #(
          .BUF_DEPTH (BUF_DEPTH),
          .THRESH    (THRESH),
          .ATOMIC    (ATOMIC),
          .CNT_W     (CNT_W)
        ) u_cnt (
          .clk         (clk),
          .rst         (rst),
          .alloc       (vc_alloc[I]),
          .sent        (flit_sent[I]),
          .tail        (flit_tail[I]),
          .credit      (credit_in[I]),
          .cnt         (credit_cnt[I*CNT_W +: CNT_W]),
          .blocked     (vc_blocked_map[I]),
          .err_credit  (err_credit_evt[I]),
          .err_realloc (err_realloc_evt[I])
        );
      end
    end else begin : g_illegal
      // Traffic can never be routed here, so events are dropped and state is pinned idle.
      logic unused_evt;
      assign unused_evt = ^{vc_alloc[p*NV +: NV], flit_sent[p*NV +: NV],
                            flit_tail[p*NV +: NV], credit_in[p*NV +: NV]};
      assign err_credit_evt[p*NV +: NV]  = '0;
      assign err_realloc_evt[p*NV +: NV] = '0;
      assign vc_blocked_map[p*NV +: NV]  = '0;
      for (genvar v = 0; v < NV; v++) begin : g_vc
        assign credit_cnt[(p*NV+v)*CNT_W +: CNT_W] = CNT_W'(BUF_DEPTH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_credit  <= 1'b0;
      err_realloc <= 1'b0;
    end else begin
      err_credit  <= err_credit  | (|err_credit_evt);
      err_realloc <= err_realloc | (|err_realloc_evt);
    end
  end

  // Non-one-hot selects naturally give the OR over every selected (port, VC) pair.
  always_comb begin
    vc_full_blocked = 1'b0;
    for (int p = 0; p < NP; p++) begin
      for (int v = 0; v < NV; v++) begin
        vc_full_blocked = vc_full_blocked |
                          (vc_blocked_map[p*NV+v] & output_port_sw[p] & vc_blocked_chk[v]);
      end
    end
  end

endmodule
